sync_frame_tx: RTL and testbench

SYNC_FRAME_TX -- requirements
Module: sync_frame_tx

---
 rtl/sync_frame_tx.sv | 141 ++++++++++++++
 tb/tb_sync_frame_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sync_frame_tx.sv
// Serial sync-frame transmitter: sends a latched timestamp as start bit, LSB-first data and stop bit.
// Optional even-parity bit between data and stop when SYNC_FRAME_TX_PARITY_EN is defined.
module sync_frame_tx #(
  parameter int DIV   = 4,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  output logic             TXD,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] TS
);

  localparam int DIV_W = $clog2(DIV);
  localparam int BIT_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CNT_W - 1);

`ifdef SYNC_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, STRT, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, STRT, DATA, STOP} state_t;
`endif

  state_t             state_reg;
  logic [CNT_W-1:0]   ts_reg;
  logic [CNT_W-1:0]   shift_reg;
  logic [DIV_W-1:0]   div_reg;
  logic [BIT_W-1:0]   bit_reg;
  logic               txd_reg;
  logic               busy_reg;
  logic               done_reg;
`ifdef SYNC_FRAME_TX_PARITY_EN
  logic               par_reg;
`endif

  logic div_last;
  logic bit_last;

  assign div_last = (div_reg == DIV_LAST);
  assign bit_last = (bit_reg == BIT_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
      ts_reg    <= '0;
      shift_reg <= '0;
      div_reg   <= '0;
      bit_reg   <= '0;
      txd_reg   <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      ts_reg   <= ts_reg + CNT_W'(1);
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (START) begin
            // Latch the pre-increment counter value seen at this edge
            shift_reg <= ts_reg;
`ifdef SYNC_FRAME_TX_PARITY_EN
            par_reg   <= ^ts_reg;
`endif
            div_reg   <= '0;
            txd_reg   <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= STRT;
          end
        end
        STRT: begin
          if (div_last) begin
            div_reg   <= '0;
            bit_reg   <= '0;
            txd_reg   <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state_reg <= DATA;
          end else begin
            div_reg <= div_reg + DIV_W'(1);
          end
        end
        DATA: begin
          if (div_last) begin
            div_reg <= '0;
            if (bit_last) begin
`ifdef SYNC_FRAME_TX_PARITY_EN
              txd_reg   <= par_reg;
              state_reg <= PAR;
`else
              txd_reg   <= 1'b1;
              state_reg <= STOP;
`endif
            end else begin
              bit_reg   <= bit_reg + BIT_W'(1);
              txd_reg   <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            div_reg <= div_reg + DIV_W'(1);
          end
        end
`ifdef SYNC_FRAME_TX_PARITY_EN
        PAR: begin
          if (div_last) begin
            div_reg   <= '0;
            txd_reg   <= 1'b1;
            state_reg <= STOP;
          end else begin
            div_reg <= div_reg + DIV_W'(1);
          end
        end
`endif
        STOP: begin
          if (div_last) begin
            div_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end else begin
            div_reg <= div_reg + DIV_W'(1);
          end
        end
        default: begin
          txd_reg   <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign TXD  = txd_reg;
  assign BUSY = busy_reg;
  assign DONE = done_reg;
  assign TS   = ts_reg;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx (DIV=4, CNT_W=8); follows SYNC_FRAME_TX_PARITY_EN when defined.
module tb_sync_frame_tx;

  localparam int DIV   = 4;
  localparam int CNT_W = 8;
`ifdef SYNC_FRAME_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (2 + CNT_W + P) * DIV;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             START = 1'b0;
  logic             TXD;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] TS;

  int checks = 0;
  int errors = 0;

  sync_frame_tx #(.DIV(DIV), .CNT_W(CNT_W)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .START(START),
    .TXD  (TXD),
    .BUSY (BUSY),
    .DONE (DONE),
    .TS   (TS)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for cycle i (0-based) of a frame carrying v
  function automatic logic exp_bit(input logic [CNT_W-1:0] v, input int i);
    int seg;
    seg = i / DIV;
    if (seg == 0) return 1'b0;
    if (seg <= CNT_W) return v[seg-1];
    if (P == 1 && seg == CNT_W + 1) return ^v;
    return 1'b1;
  endfunction

  // Called in cycle 1 of a frame; returns in the DONE cycle
  task automatic check_frame(input string tag, input logic [CNT_W-1:0] v);
    for (int i = 0; i < FRAME; i++) begin
      check({tag, "_txd"}, {31'd0, TXD}, {31'd0, exp_bit(v, i)});
      check({tag, "_busy"}, {31'd0, BUSY}, 32'd1);
      check({tag, "_done_low"}, {31'd0, DONE}, 32'd0);
      tick();
    end
    check({tag, "_end_busy"}, {31'd0, BUSY}, 32'd0);
    check({tag, "_end_done"}, {31'd0, DONE}, 32'd1);
    check({tag, "_end_txd"}, {31'd0, TXD}, 32'd1);
  endtask

  task automatic wait_ts(input logic [CNT_W-1:0] v);
    int n;
    n = 0;
    while (TS !== v && n < 300) begin
      tick();
      n++;
    end
    check("wait_ts", {24'd0, TS}, {24'd0, v});
  endtask

  logic [CNT_W-1:0] t0;

  initial begin
    // Reset with START high: must be ignored
    RESET = 1'b1;
    START = 1'b1;
    tick();
    tick();
    check("rst_txd", {31'd0, TXD}, 32'd1);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    check("rst_ts", {24'd0, TS}, 32'd0);
    RESET = 1'b0;
    START = 1'b0;
    tick();
    check("ts_first_inc", {24'd0, TS}, 32'd1);
    check("idle_busy", {31'd0, BUSY}, 32'd0);

    // Frame carrying 0x05: line 0 x4, 1,0,1,0,0,0,0,0, (parity 0), 1 x4
    wait_ts(8'h05);
    START = 1'b1;
    tick();
    START = 1'b0;
    check_frame("f05", 8'h05);
    tick();
    check("f05_done_once", {31'd0, DONE}, 32'd0);
    check("f05_idle_txd", {31'd0, TXD}, 32'd1);

    // Frame carrying 0x07 (odd weight, parity 1)
    wait_ts(8'h07);
    START = 1'b1;
    tick();
    START = 1'b0;
    check_frame("f07", 8'h07);
    tick();

    // START held high: back-to-back frames, latched values step by FRAME+1
    t0 = TS;
    START = 1'b1;
    tick();
    check_frame("rep0", t0);
    check("rep_ts1", {24'd0, TS}, {24'd0, t0 + 8'(FRAME + 1)});
    tick();
    check_frame("rep1", t0 + 8'(FRAME + 1));
    check("rep_ts2", {24'd0, TS}, {24'd0, t0 + 8'(2 * (FRAME + 1))});
    START = 1'b0;
    tick();
    check("rep_stop_busy", {31'd0, BUSY}, 32'd0);

    // Reset during data bit 3 abandons the frame
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) tick();
    check("mid_busy", {31'd0, BUSY}, 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("abort_txd", {31'd0, TXD}, 32'd1);
    check("abort_busy", {31'd0, BUSY}, 32'd0);
    check("abort_ts", {24'd0, TS}, 32'd0);
    check("abort_done", {31'd0, DONE}, 32'd0);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      check("abort_no_done", {31'd0, DONE}, 32'd0);
    end
    t0 = TS;
    START = 1'b1;
    tick();
    START = 1'b0;
    check_frame("after_abort", t0);

    // Full TS sweep from reset; START at 0xFF latches all ones
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    for (int k = 0; k < 256; k++) begin
      check("sweep_ts", {24'd0, TS}, k);
      if (k == 255) START = 1'b1;
      tick();
    end
    START = 1'b0;
    check("sweep_wrap", {24'd0, TS}, 32'd0);
    check_frame("fff", 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
